// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_pkg : shared state encoding and default constants for spi_mstr |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } spi_state_t;

  localparam int DEFAULT_SCLK_DIV = 32;
  localparam int DEFAULT_PORCH    = 16;
  localparam int FRAME_BITS       = 16;

endpackage
`default_nettype wire

// File: rtl/spi_mstr_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_mstr_if : command-side and serial-side signals of spi_mstr     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface spi_mstr_if;
  import spi_pkg::*;

  logic                  wrt_SPI;
  logic [FRAME_BITS-1:0] SPI_data;
  logic [2:0]            ss;
  logic                  MISO;
  logic                  SCLK;
  logic                  MOSI;
  logic [7:0]            SS_n;
  logic                  SPI_done;
  logic [FRAME_BITS-1:0] rd_data;
  logic [7:0]            EEP_data;
  logic                  busy;

  modport master (
    input  wrt_SPI, SPI_data, ss, MISO,
    output SCLK, MOSI, SS_n, SPI_done, rd_data, EEP_data, busy
  );

  modport slave (
    output wrt_SPI, SPI_data, ss, MISO,
    input  SCLK, MOSI, SS_n, SPI_done, rd_data, EEP_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_mstr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_mstr : SPI mode-0 master, 16-bit frames, 8 one-hot selects     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_mstr
  import spi_pkg::*;
#(
  parameter int SCLK_DIV = DEFAULT_SCLK_DIV,
  parameter int PORCH    = DEFAULT_PORCH
) (
  input  logic        clk,
  input  logic        rst,
  spi_mstr_if.master  bus
);

  localparam int DIV_W   = $clog2(SCLK_DIV);
  localparam int PORCH_W = (PORCH > 1) ? $clog2(PORCH) : 1;
  localparam int CNT_W   = (DIV_W > PORCH_W) ? DIV_W : PORCH_W;
  localparam int BIT_W   = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_MID    = CNT_W'(SCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] PORCH_LAST = CNT_W'(PORCH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  spi_state_t            state,     nxt_state;
  logic [CNT_W-1:0]      cnt,       nxt_cnt;
  logic [BIT_W-1:0]      bit_cnt,   nxt_bit_cnt;
  logic [FRAME_BITS-1:0] shift,     nxt_shift;
  logic [2:0]            ss_lat,    nxt_ss_lat;
  logic                  miso_smpl, nxt_miso_smpl;
  logic                  sclk_r,    nxt_sclk;
  logic [7:0]            ss_n_r,    nxt_ss_n;
  logic                  done_r,    nxt_done;
  logic                  busy_r,    nxt_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      ss_lat    <= '0;
      miso_smpl <= 1'b0;
      sclk_r    <= 1'b0;
      ss_n_r    <= 8'hFF;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      bit_cnt   <= nxt_bit_cnt;
      shift     <= nxt_shift;
      ss_lat    <= nxt_ss_lat;
      miso_smpl <= nxt_miso_smpl;
      sclk_r    <= nxt_sclk;
      ss_n_r    <= nxt_ss_n;
      done_r    <= nxt_done;
      busy_r    <= nxt_busy;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_bit_cnt   = bit_cnt;
    nxt_shift     = shift;
    nxt_ss_lat    = ss_lat;
    nxt_miso_smpl = miso_smpl;
    nxt_done      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.wrt_SPI) begin
          nxt_state   = FRONT;
          nxt_shift   = bus.SPI_data;
          nxt_ss_lat  = bus.ss;
          nxt_cnt     = '0;
          nxt_bit_cnt = '0;
        end
      end
      FRONT: begin
        if (cnt == PORCH_LAST) begin
          nxt_state = SHIFT;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      SHIFT: begin
        nxt_cnt = (cnt == DIV_LAST) ? '0 : cnt + 1'b1;
        // Sample one clk ahead of the SCLK rise; shift on the SCLK fall.
        if (cnt == DIV_MID) begin
          nxt_miso_smpl = bus.MISO;
        end
        if (cnt == DIV_LAST) begin
          nxt_shift   = {shift[FRAME_BITS-2:0], miso_smpl};
          nxt_bit_cnt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            nxt_state = BACK;
          end
        end
      end
      BACK: begin
        if (cnt == PORCH_LAST) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
          nxt_done  = 1'b1;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    // Outputs are precomputed from next-state values so they leave flops.
    nxt_busy = (nxt_state != IDLE);
    nxt_sclk = (nxt_state == SHIFT) ? nxt_cnt[DIV_W-1] : 1'b0;
    nxt_ss_n = (nxt_state == IDLE) ? 8'hFF : ~(8'h01 << nxt_ss_lat);
  end

  assign bus.SCLK     = sclk_r;
  assign bus.MOSI     = shift[FRAME_BITS-1];
  assign bus.SS_n     = ss_n_r;
  assign bus.SPI_done = done_r;
  assign bus.rd_data  = shift;
  assign bus.EEP_data = shift[7:0];
  assign bus.busy     = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_spi_mstr.sv
`default_nettype none
// Scoreboard bench for spi_mstr: stimulus pushes expected frames, a monitor
// reconstructs each frame from the pins and checks it at SPI_done.
module tb_spi_mstr;
  import spi_pkg::*;

  typedef struct {
    logic [15:0] rd;
    logic [15:0] tx;
    logic [7:0]  ssn;
    logic [7:0]  follow;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  exp_t        e;
  logic        loopback;
  logic [15:0] slave_word;
  logic [15:0] sl_sh = 16'h0;

  spi_mstr_if bus ();

  spi_mstr #(.SCLK_DIV(32), .PORCH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.MISO = loopback ? bus.MOSI : sl_sh[15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / slave model ----------------
  logic        prev_sclk = 1'b0;
  logic [7:0]  prev_ssn = 8'hFF;
  int          rises = 0;
  int          last_rise = 0;
  logic [15:0] tx_bits = 16'h0;
  logic [7:0]  ssn_seen = 8'hFF;
  bit          ssn_changed = 0;
  bit          period_bad = 0;
  bit          follow_pend = 0;
  logic [7:0]  follow_exp = 8'hFF;

  always @(negedge clk) begin
    if (follow_pend) begin
      check("ss_n_after_done", {24'h0, bus.SS_n}, {24'h0, follow_exp});
      follow_pend = 0;
    end
    if (bus.SS_n !== 8'hFF && prev_ssn === 8'hFF) begin
      rises = 0; tx_bits = 16'h0; period_bad = 0; ssn_changed = 0;
      ssn_seen = bus.SS_n;
    end else if (bus.SS_n !== 8'hFF && bus.SS_n !== ssn_seen) begin
      ssn_changed = 1;
    end
    if (bus.SCLK === 1'b1 && prev_sclk === 1'b0) begin
      if (rises > 0 && (cyc - last_rise) != 32) period_bad = 1;
      last_rise = cyc;
      rises++;
      tx_bits = {tx_bits[14:0], bus.MOSI};
    end
    if (bus.SS_n[4] === 1'b0 && prev_ssn[4] === 1'b1) sl_sh = slave_word;
    else if (bus.SCLK === 1'b0 && prev_sclk === 1'b1) sl_sh = {sl_sh[14:0], 1'b0};

    if (bus.SPI_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got SPI_done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("rd_data",    {16'h0, bus.rd_data},  {16'h0, e.rd});
        check("EEP_data",   {24'h0, bus.EEP_data}, {24'h0, e.rd[7:0]});
        check("mosi_bits",  {16'h0, tx_bits},      {16'h0, e.tx});
        check("sclk_rises", rises,                 32'd16);
        check("sclk_period_bad", {31'h0, period_bad}, 32'd0);
        check("ss_n_frame", {24'h0, ssn_seen},     {24'h0, e.ssn});
        check("ss_n_changed", {31'h0, ssn_changed}, 32'd0);
        check("done_cycle", cyc,                   e.done_cyc);
        follow_pend = 1;
        follow_exp  = e.follow;
      end
    end
    prev_sclk = bus.SCLK;
    prev_ssn  = bus.SS_n;
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic [15:0] rd, input logic [15:0] tx, input logic [7:0] ssn,
                          input logic [7:0] follow, input int done_cyc);
    exp_t x;
    x.rd = rd; x.tx = tx; x.ssn = ssn; x.follow = follow; x.done_cyc = done_cyc;
    sb.push_back(x);
  endtask

  task automatic send(input logic [15:0] d, input logic [2:0] s, output int c0);
    @(negedge clk);
    bus.wrt_SPI  = 1'b1;
    bus.SPI_data = d;
    bus.ss       = s;
    c0           = cyc;
  endtask

  task automatic release_wrt();
    @(negedge clk);
    bus.wrt_SPI = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && bus.busy === 1'b0) break;
    end
    check("drain", {31'h0, (sb.size() == 0 && bus.busy === 1'b0)}, 32'd1);
    @(negedge clk);
  endtask

  int c0;

  initial begin
    rst = 1'b1; bus.wrt_SPI = 1'b0; bus.SPI_data = 16'h0; bus.ss = 3'd0;
    loopback = 1'b1; slave_word = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_ss_n",     {24'h0, bus.SS_n},     32'hFF);
    check("rst_sclk",     {31'h0, bus.SCLK},     32'd0);
    check("rst_busy",     {31'h0, bus.busy},     32'd0);
    check("rst_done",     {31'h0, bus.SPI_done}, 32'd0);
    check("rst_mosi",     {31'h0, bus.MOSI},     32'd0);
    check("rst_rd_data",  {16'h0, bus.rd_data},  32'h0);
    check("rst_eep_data", {24'h0, bus.EEP_data}, 32'h0);
    // Start strobe while reset is held must be ignored
    bus.wrt_SPI = 1'b1; bus.SPI_data = 16'hBEEF; bus.ss = 3'd1;
    @(negedge clk);
    check("rst_wrt_busy", {31'h0, bus.busy},     32'd0);
    check("rst_wrt_ss_n", {24'h0, bus.SS_n},     32'hFF);
    bus.wrt_SPI = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Loopback frame, slave 0
    send(16'h1302, 3'd0, c0);
    push_exp(16'h1302, 16'h1302, 8'hFE, 8'hFF, c0 + 545);
    release_wrt();
    drain();

    // EEPROM read from slave 4
    loopback = 1'b0; slave_word = 16'h005A;
    send(16'h0005, 3'd4, c0);
    push_exp(16'h005A, 16'h0005, 8'hEF, 8'hFF, c0 + 545);
    release_wrt();
    drain();
    check("eep_after_done", {24'h0, bus.EEP_data}, 32'h5A);
    loopback = 1'b1;

    // Strobe mid-frame is ignored
    send(16'h1346, 3'd1, c0);
    push_exp(16'h1346, 16'h1346, 8'hFD, 8'hFF, c0 + 545);
    release_wrt();
    while (cyc < c0 + 100) @(negedge clk);
    bus.wrt_SPI = 1'b1; bus.SPI_data = 16'hFFFF; bus.ss = 3'd6;
    release_wrt();
    drain();

    // Reset mid-frame aborts without SPI_done
    send(16'hABCD, 3'd2, c0);
    release_wrt();
    while (cyc < c0 + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss_n", {24'h0, bus.SS_n}, 32'hFF);
    check("abort_sclk", {31'h0, bus.SCLK}, 32'd0);
    check("abort_busy", {31'h0, bus.busy}, 32'd0);
    check("abort_rd",   {16'h0, bus.rd_data}, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(16'h5AA5, 3'd3, c0);
    push_exp(16'h5AA5, 16'h5AA5, 8'hF7, 8'hFF, c0 + 545);
    release_wrt();
    drain();

    // Held strobe: back-to-back frames on slave 7
    send(16'hC3E1, 3'd7, c0);
    push_exp(16'hC3E1, 16'hC3E1, 8'h7F, 8'h7F, c0 + 545);
    push_exp(16'hC3E1, 16'hC3E1, 8'h7F, 8'h7F, c0 + 1090);
    push_exp(16'hC3E1, 16'hC3E1, 8'h7F, 8'hFF, c0 + 1635);
    while (cyc < c0 + 1091) @(negedge clk);
    bus.wrt_SPI = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_mstr.md
SPI_MSTR -- requirements
Module: spi_mstr

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 32, meaning clk cycles per SCLK period (power of two, at least 4).
REQ-002 SHALL have parameter PORCH, default 16, meaning clk cycles SCLK is held low after SS_n falls and before SS_n rises.
REQ-003 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wrt_SPI  input  1  one-cycle start strobe from the command processor.
REQ-006 SPI_data  input  16  frame to transmit, MSB first; sampled only when wrt_SPI is accepted.
REQ-007 ss  input  3  slave index; sampled only when wrt_SPI is accepted.
REQ-008 MISO  input  1  serial data from the selected slave.
REQ-009 SCLK  output  1  serial clock, CPOL=0, CPHA=0.
REQ-010 MOSI  output  1  serial data to the slaves.
REQ-011 SS_n  output  8  active-low one-hot slave selects.
REQ-012 SPI_done  output  1  one-cycle pulse marking the end of a frame.
REQ-013 rd_data  output  16  received frame.
REQ-014 EEP_data  output  8  rd_data[7:0] (calibration EEPROM read byte).
REQ-015 busy  output  1  high while a frame is in progress.

Function
REQ-016 SHALL implement FSM states IDLE, FRONT, SHIFT, BACK.
REQ-017 IDLE with wrt_SPI=1: latch SPI_data into a 16-bit shift register, latch ss, clear counters, go to FRONT.
REQ-018 wrt_SPI in any state other than IDLE SHALL be ignored; the latched frame and ss are unchanged.
REQ-019 SS_n SHALL be ~(8'h01 << ss_latched) in FRONT, SHIFT and BACK, and 8'hFF in IDLE.
REQ-020 FRONT: SCLK=0 for exactly PORCH cycles, then go to SHIFT.
REQ-021 SHIFT: 5-bit divider cnt counts 0 to SCLK_DIV-1 and wraps; SCLK = MSB of cnt (low for the first half of each period, high for the second half).
REQ-022 MOSI SHALL equal shift-register bit 15 at all times, so MOSI is stable across every SCLK rising edge.
REQ-023 On the cycle before the SCLK rising edge (cnt = SCLK_DIV/2-1), MISO SHALL be captured into miso_smpl.
REQ-024 At cnt = SCLK_DIV-1 (SCLK falling edge), shift register SHALL become {shift[14:0], miso_smpl} and the 4-bit bit_cnt SHALL increment.
REQ-025 After the 16th shift (bit_cnt = 15 at cnt = SCLK_DIV-1), go to BACK with SCLK=0; exactly 16 SCLK rising edges occur per frame.
REQ-026 BACK: SCLK=0 for PORCH cycles, then go to IDLE; on that IDLE cycle SS_n=8'hFF and SPI_done=1 for one cycle.
REQ-027 Latency with defaults: taking the wrt_SPI cycle as cycle 0, SPI_done SHALL be high in cycle 545 only (1 + 16 + 512 + 16).
REQ-028 rd_data SHALL equal the shift register; it is valid from the SPI_done cycle and held until the next accepted wrt_SPI.
REQ-029 busy SHALL be high in FRONT, SHIFT and BACK.
REQ-030 wrt_SPI in the SPI_done cycle SHALL be accepted, giving back-to-back frames with SS_n high for exactly one cycle between them.
REQ-031 All outputs SHALL be registered or driven directly from registers; no combinational path from any input to any output.

Reset
REQ-032 rst=1 SHALL force, at the next clk edge: state IDLE, SCLK=0, SS_n=8'hFF, SPI_done=0, busy=0, shift register 16'h0000 (hence MOSI=0, rd_data=0, EEP_data=0), cnt=0, bit_cnt=0.
REQ-033 rst asserted mid-frame SHALL abort the frame with no SPI_done pulse; wrt_SPI asserted during rst is ignored.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum (spi_state_t) and the default constants SCLK_DIV=32, PORCH=16, FRAME_BITS=16.
REQ-035 The block SHALL be a single module with no sub-modules; the ss-to-SS_n decode is inline.

Verification
REQ-036 Loopback: MISO tied to MOSI, wrt_SPI with SPI_data=16'h1302, ss=0 -> SS_n=8'hFE, 16 SCLK rises, SCLK period 32 clks, rd_data=16'h1302, SPI_done in cycle 545 only.
REQ-037 EEPROM read: ss=4, SPI_data=16'h0005, slave model returns 16'h005A -> SS_n=8'hEF during the frame, EEP_data=8'h5A at SPI_done, MOSI bits observed at SCLK rises = 16'h0005.
REQ-038 wrt_SPI with SPI_data=16'hFFFF at cycle 100 during a frame started at cycle 0 with 16'h1346 -> ignored; transmitted MOSI = 16'h1346; single SPI_done at cycle 545.
REQ-039 rst pulsed at cycle 300 mid-frame -> next cycle SS_n=8'hFF, SCLK=0, busy=0; no SPI_done; a new wrt_SPI then completes normally.
REQ-040 wrt_SPI held high continuously with ss=7 -> frames repeat; each SPI_done is followed by SS_n=8'h7F one cycle later; spacing between SPI_done pulses is 545 cycles.
